// File: rtl/letc_core_stage_w_multi.sv
// letc_core_stage_w_multi
// Multi-lane writeback stage. Each lane registers one completed
// instruction from E2, formats load data (byte/half/word, sign or zero
// extension) and drives one register-file write port. When several lanes
// write the same rd in one cycle, only the highest (youngest) lane writes.
// Writes to x0 are suppressed.
//
// Optional feature macro: LETC_CORE_STAGE_W_RETIRE_CNT_EN
//   defined   : CNT_W-bit wrapping retire counter on o_retire_cnt
//   undefined : no counter flops, no o_retire_cnt port
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   o_stage_ready         ~i_stage_stall
//   i_stage_flush         invalidate all registered lanes
//   i_stage_stall         hold lanes, block writes and capture
//   i_e2_*                per-lane E2 instruction fields
//   o_rd_idx/wdata/wen    per-lane register-file write ports
//   o_retire_cnt          retired-instruction count (macro build only)

module letc_core_stage_w_multi #(
   parameter int LANES = 2,
   parameter int CNT_W = 64
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   output logic                    o_stage_ready,
   input  logic                    i_stage_flush,
   input  logic                    i_stage_stall,
   input  logic [LANES-1:0]        i_e2_valid,
   input  logic [LANES-1:0][4:0]   i_e2_rd_idx,
   input  logic [LANES-1:0]        i_e2_rd_wen,
   input  logic [LANES-1:0][31:0]  i_e2_wdata,
   input  logic [LANES-1:0]        i_e2_is_load,
   input  logic [LANES-1:0][1:0]   i_e2_mem_size,
   input  logic [LANES-1:0]        i_e2_mem_unsigned,
   input  logic [LANES-1:0][1:0]   i_e2_byte_off,
   output logic [LANES-1:0][4:0]   o_rd_idx,
   output logic [LANES-1:0][31:0]  o_rd_wdata,
   output logic [LANES-1:0]        o_rd_wen
`ifdef LETC_CORE_STAGE_W_RETIRE_CNT_EN
   ,
   output logic [CNT_W-1:0]        o_retire_cnt
`endif
);

   logic [LANES-1:0]        valid_q,        valid_d;
   logic [LANES-1:0][4:0]   rd_idx_q,       rd_idx_d;
   logic [LANES-1:0]        rd_wen_q,       rd_wen_d;
   logic [LANES-1:0][31:0]  wdata_q,        wdata_d;
   logic [LANES-1:0]        is_load_q,      is_load_d;
   logic [LANES-1:0][1:0]   mem_size_q,     mem_size_d;
   logic [LANES-1:0]        mem_unsigned_q, mem_unsigned_d;
   logic [LANES-1:0][1:0]   byte_off_q,     byte_off_d;

   logic [LANES-1:0]        wen_raw;

   function automatic logic [31:0] fmt_load(input logic [31:0] w,
                                            input logic [1:0]  size,
                                            input logic        uns,
                                            input logic [1:0]  off);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      // off[0] is ignored for halves: E2 only issues aligned half loads
      h = off[1] ? w[31:16] : w[15:0];
      case (size)
         2'd0:    r = {{24{b[7] & ~uns}}, b};
         2'd1:    r = {{16{h[15] & ~uns}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

   assign o_stage_ready = ~i_stage_stall;

   // Data fields hold on flush; only valid matters for discarded lanes.
   always_comb begin
      valid_d        = valid_q;
      rd_idx_d       = rd_idx_q;
      rd_wen_d       = rd_wen_q;
      wdata_d        = wdata_q;
      is_load_d      = is_load_q;
      mem_size_d     = mem_size_q;
      mem_unsigned_d = mem_unsigned_q;
      byte_off_d     = byte_off_q;
      if (i_stage_flush) begin
         valid_d = '0;
      end else if (!i_stage_stall) begin
         valid_d        = i_e2_valid;
         rd_idx_d       = i_e2_rd_idx;
         rd_wen_d       = i_e2_rd_wen;
         wdata_d        = i_e2_wdata;
         is_load_d      = i_e2_is_load;
         mem_size_d     = i_e2_mem_size;
         mem_unsigned_d = i_e2_mem_unsigned;
         byte_off_d     = i_e2_byte_off;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q        <= '0;
         rd_idx_q       <= '0;
         rd_wen_q       <= '0;
         wdata_q        <= '0;
         is_load_q      <= '0;
         mem_size_q     <= '0;
         mem_unsigned_q <= '0;
         byte_off_q     <= '0;
      end else begin
         valid_q        <= valid_d;
         rd_idx_q       <= rd_idx_d;
         rd_wen_q       <= rd_wen_d;
         wdata_q        <= wdata_d;
         is_load_q      <= is_load_d;
         mem_size_q     <= mem_size_d;
         mem_unsigned_q <= mem_unsigned_d;
         byte_off_q     <= byte_off_d;
      end
   end

   always_comb begin
      o_rd_idx   = rd_idx_q;
      o_rd_wdata = '0;
      for (int k = 0; k < LANES; k++) begin
         o_rd_wdata[k] = is_load_q[k]
                         ? fmt_load(wdata_q[k], mem_size_q[k], mem_unsigned_q[k], byte_off_q[k])
                         : wdata_q[k];
      end
   end

   // A lane loses its write if any younger (higher) lane writes the same rd.
   always_comb begin
      wen_raw  = '0;
      o_rd_wen = '0;
      for (int k = 0; k < LANES; k++) begin
         wen_raw[k] = valid_q[k] & rd_wen_q[k] & (rd_idx_q[k] != 5'd0) & ~i_stage_stall;
      end
      for (int k = 0; k < LANES; k++) begin
         o_rd_wen[k] = wen_raw[k];
         for (int m = k + 1; m < LANES; m++) begin
            if (wen_raw[m] && (rd_idx_q[m] == rd_idx_q[k])) begin
               o_rd_wen[k] = 1'b0;
            end
         end
      end
   end

`ifdef LETC_CORE_STAGE_W_RETIRE_CNT_EN
   logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
   logic [2:0]       retire_pop;

   // Every valid lane retires, including rd_wen=0 and rd=x0 instructions.
   always_comb begin
      retire_pop = '0;
      for (int k = 0; k < LANES; k++) begin
         retire_pop = retire_pop + {2'b00, valid_q[k]};
      end
      retire_cnt_d = retire_cnt_q;
      if (!i_stage_stall) begin
         retire_cnt_d = retire_cnt_q + CNT_W'(retire_pop);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         retire_cnt_q <= '0;
      end else begin
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign o_retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_letc_core_stage_w_multi.sv
module tb_letc_core_stage_w_multi;

   localparam int LANES = 2;
   localparam int CNT_W = 4;

   logic                    i_clk = 1'b0;
   logic                    i_rst_n;
   logic                    o_stage_ready;
   logic                    i_stage_flush;
   logic                    i_stage_stall;
   logic [LANES-1:0]        i_e2_valid;
   logic [LANES-1:0][4:0]   i_e2_rd_idx;
   logic [LANES-1:0]        i_e2_rd_wen;
   logic [LANES-1:0][31:0]  i_e2_wdata;
   logic [LANES-1:0]        i_e2_is_load;
   logic [LANES-1:0][1:0]   i_e2_mem_size;
   logic [LANES-1:0]        i_e2_mem_unsigned;
   logic [LANES-1:0][1:0]   i_e2_byte_off;
   logic [LANES-1:0][4:0]   o_rd_idx;
   logic [LANES-1:0][31:0]  o_rd_wdata;
   logic [LANES-1:0]        o_rd_wen;
   logic [CNT_W-1:0]        retire_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model: registered lane contents and retire count
   logic        m_valid[LANES];
   logic [4:0]  m_idx[LANES];
   logic        m_wen[LANES];
   logic [31:0] m_data[LANES];
   logic        m_load[LANES];
   logic [1:0]  m_size[LANES];
   logic        m_uns[LANES];
   logic [1:0]  m_off[LANES];
   logic [CNT_W-1:0] m_cnt;

   always #5 i_clk = ~i_clk;

   letc_core_stage_w_multi #(.LANES(LANES), .CNT_W(CNT_W)) dut (
      .i_clk             (i_clk),
      .i_rst_n           (i_rst_n),
      .o_stage_ready     (o_stage_ready),
      .i_stage_flush     (i_stage_flush),
      .i_stage_stall     (i_stage_stall),
      .i_e2_valid        (i_e2_valid),
      .i_e2_rd_idx       (i_e2_rd_idx),
      .i_e2_rd_wen       (i_e2_rd_wen),
      .i_e2_wdata        (i_e2_wdata),
      .i_e2_is_load      (i_e2_is_load),
      .i_e2_mem_size     (i_e2_mem_size),
      .i_e2_mem_unsigned (i_e2_mem_unsigned),
      .i_e2_byte_off     (i_e2_byte_off),
      .o_rd_idx          (o_rd_idx),
      .o_rd_wdata        (o_rd_wdata),
      .o_rd_wen          (o_rd_wen)
`ifdef LETC_CORE_STAGE_W_RETIRE_CNT_EN
      ,
      .o_retire_cnt      (retire_cnt)
`endif
   );

`ifndef LETC_CORE_STAGE_W_RETIRE_CNT_EN
   assign retire_cnt = '0;
`endif

   function automatic logic [31:0] ref_fmt(input logic [31:0] w, input logic [1:0] size,
                                           input logic uns, input logic [1:0] off);
      logic [31:0] v;
      if (size == 2'd0) begin
         v = (w >> (8 * off)) & 32'h0000_00FF;
         if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (size == 2'd1) begin
         v = (w >> ((off >= 2) ? 16 : 0)) & 32'h0000_FFFF;
         if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < LANES; k++) begin
         m_valid[k] = 0; m_idx[k] = 0; m_wen[k] = 0; m_data[k] = 0;
         m_load[k] = 0; m_size[k] = 0; m_uns[k] = 0; m_off[k] = 0;
      end
      m_cnt = '0;
   endtask

   task automatic clock_edge();
      @(posedge i_clk);
      if (!i_stage_stall) begin
         for (int k = 0; k < LANES; k++) if (m_valid[k]) m_cnt = m_cnt + 1'b1;
      end
      if (i_stage_flush) begin
         for (int k = 0; k < LANES; k++) m_valid[k] = 0;
      end else if (!i_stage_stall) begin
         for (int k = 0; k < LANES; k++) begin
            m_valid[k] = i_e2_valid[k];    m_idx[k]  = i_e2_rd_idx[k];
            m_wen[k]   = i_e2_rd_wen[k];   m_data[k] = i_e2_wdata[k];
            m_load[k]  = i_e2_is_load[k];  m_size[k] = i_e2_mem_size[k];
            m_uns[k]   = i_e2_mem_unsigned[k]; m_off[k] = i_e2_byte_off[k];
         end
      end
      #1;
   endtask

   task automatic drive_idle();
      i_stage_flush = 0; i_stage_stall = 0;
      i_e2_valid = '0; i_e2_rd_idx = '0; i_e2_rd_wen = '0; i_e2_wdata = '0;
      i_e2_is_load = '0; i_e2_mem_size = '0; i_e2_mem_unsigned = '0; i_e2_byte_off = '0;
   endtask

   task automatic drive_lane(input int k, input logic [4:0] idx, input logic [31:0] wd,
                             input logic ld, input logic [1:0] sz, input logic uns,
                             input logic [1:0] off);
      i_e2_valid[k] = 1'b1; i_e2_rd_wen[k] = 1'b1; i_e2_rd_idx[k] = idx;
      i_e2_wdata[k] = wd; i_e2_is_load[k] = ld; i_e2_mem_size[k] = sz;
      i_e2_mem_unsigned[k] = uns; i_e2_byte_off[k] = off;
   endtask

   task automatic test_reset();
      i_rst_n = 0;
      drive_idle();
      model_reset();
      #12;
      checks++;
      if (o_rd_wen !== '0 || o_rd_idx !== '0 || o_rd_wdata !== '0) begin
         errors++;
         $display("FAIL reset_outputs wen=%b idx=%h wdata=%h want all zero", o_rd_wen, o_rd_idx, o_rd_wdata);
      end
      checks++;
      if (o_stage_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready got=%b want=1", o_stage_ready);
      end
      i_stage_stall = 1; #1;
      checks++;
      if (o_stage_ready !== 1'b0) begin
         errors++; $display("FAIL ready_stall got=%b want=0", o_stage_ready);
      end
      i_stage_stall = 0;
`ifdef LETC_CORE_STAGE_W_RETIRE_CNT_EN
      checks++;
      if (retire_cnt !== '0) begin
         errors++; $display("FAIL reset_cnt got=%0d want=0", retire_cnt);
      end
`endif
      i_rst_n = 1;
      clock_edge();
   endtask

   task automatic test_single_alu();
      logic [CNT_W-1:0] base;
      drive_idle();
      drive_lane(0, 5'd5, 32'hDEAD_BEEF, 0, 2'd2, 0, 2'd0);
      clock_edge();
      base = m_cnt;
      drive_idle(); #2;
      checks++;
      if (o_rd_wen !== 2'b01 || o_rd_idx[0] !== 5'd5 || o_rd_wdata[0] !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL single_alu wen=%b idx=%0d wdata=%h want wen=01 idx=5 wdata=deadbeef",
                  o_rd_wen, o_rd_idx[0], o_rd_wdata[0]);
      end
      clock_edge(); #2;
`ifdef LETC_CORE_STAGE_W_RETIRE_CNT_EN
      checks++;
      if (retire_cnt !== base + 1'b1) begin
         errors++; $display("FAIL single_alu_cnt got=%0d want=%0d", retire_cnt, base + 1'b1);
      end
`endif
   endtask

   task automatic test_loads();
      logic [1:0]  t_size[5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
      logic        t_uns[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [1:0]  t_off[5]  = '{2'd2, 2'd1, 2'd2, 2'd0, 2'd0};
      logic [31:0] t_exp[5]  = '{32'hFFFF_FFFF, 32'h0000_007F, 32'hFFFF_80FF,
                                 32'h0000_7F01, 32'h80FF_7F01};
      for (int i = 0; i < 5; i++) begin
         drive_idle();
         drive_lane(0, 5'd1, 32'h80FF_7F01, 1, t_size[i], t_uns[i], t_off[i]);
         clock_edge();
         drive_idle(); #2;
         checks++;
         if (o_rd_wdata[0] !== t_exp[i]) begin
            errors++;
            $display("FAIL load_fmt case=%0d got=%h want=%h", i, o_rd_wdata[0], t_exp[i]);
         end
      end
      clock_edge();
   endtask

   task automatic test_conflict();
      logic [CNT_W-1:0] base;
      drive_idle();
      drive_lane(0, 5'd7, 32'h1111_1111, 0, 2'd2, 0, 2'd0);
      drive_lane(1, 5'd7, 32'h2222_2222, 0, 2'd2, 0, 2'd0);
      clock_edge();
      base = m_cnt;
      drive_idle();
      drive_lane(0, 5'd0, 32'h3333_3333, 0, 2'd2, 0, 2'd0);
      drive_lane(1, 5'd9, 32'h4444_4444, 0, 2'd2, 0, 2'd0);
      #2;
      checks++;
      if (o_rd_wen !== 2'b10) begin
         errors++; $display("FAIL conflict_same_rd wen=%b want=10", o_rd_wen);
      end
      clock_edge();
      drive_idle(); #2;
      checks++;
      if (o_rd_wen !== 2'b10) begin
         errors++; $display("FAIL x0_suppress wen=%b want=10", o_rd_wen);
      end
      clock_edge(); #2;
`ifdef LETC_CORE_STAGE_W_RETIRE_CNT_EN
      checks++;
      if (retire_cnt !== base + 3'd4) begin
         errors++; $display("FAIL conflict_cnt got=%0d want=%0d", retire_cnt, base + 3'd4);
      end
`endif
   endtask

   task automatic test_stall();
      logic [CNT_W-1:0] base;
      drive_idle();
      drive_lane(0, 5'd3, 32'hCAFE_0003, 0, 2'd2, 0, 2'd0);
      clock_edge();
      base = m_cnt;
      drive_idle();
      i_stage_stall = 1;
      drive_lane(0, 5'd12, 32'h0BAD_0BAD, 0, 2'd2, 0, 2'd0);
      drive_lane(1, 5'd13, 32'h0BAD_0BAD, 0, 2'd2, 0, 2'd0);
      for (int c = 0; c < 3; c++) begin
         #2;
         checks++;
         if (o_rd_wen !== 2'b00 || o_rd_idx[0] !== 5'd3) begin
            errors++;
            $display("FAIL stall_hold cyc=%0d wen=%b idx=%0d want wen=00 idx=3", c, o_rd_wen, o_rd_idx[0]);
         end
         clock_edge();
      end
      drive_idle(); #2;
      checks++;
      if (o_rd_wen !== 2'b01 || o_rd_idx[0] !== 5'd3 || o_rd_wdata[0] !== 32'hCAFE_0003) begin
         errors++;
         $display("FAIL stall_release wen=%b idx=%0d wdata=%h want wen=01 idx=3 wdata=cafe0003",
                  o_rd_wen, o_rd_idx[0], o_rd_wdata[0]);
      end
      clock_edge(); #2;
      checks++;
      if (o_rd_wen !== 2'b00) begin
         errors++; $display("FAIL stall_once wen=%b want=00", o_rd_wen);
      end
`ifdef LETC_CORE_STAGE_W_RETIRE_CNT_EN
      checks++;
      if (retire_cnt !== base + 1'b1) begin
         errors++; $display("FAIL stall_cnt got=%0d want=%0d", retire_cnt, base + 1'b1);
      end
`endif
   endtask

   task automatic test_flush();
      logic [CNT_W-1:0] base;
      drive_idle();
      drive_lane(0, 5'd4, 32'h0000_0044, 0, 2'd2, 0, 2'd0);
      drive_lane(1, 5'd5, 32'h0000_0055, 0, 2'd2, 0, 2'd0);
      clock_edge();
      base = m_cnt;
      i_stage_flush = 1; i_stage_stall = 1;
      drive_lane(0, 5'd10, 32'h1010_1010, 0, 2'd2, 0, 2'd0);
      drive_lane(1, 5'd11, 32'h1111_1111, 0, 2'd2, 0, 2'd0);
      clock_edge();
      drive_idle(); #2;
      checks++;
      if (o_rd_wen !== 2'b00) begin
         errors++; $display("FAIL flush_wen wen=%b want=00", o_rd_wen);
      end
      clock_edge(); #2;
`ifdef LETC_CORE_STAGE_W_RETIRE_CNT_EN
      checks++;
      if (retire_cnt !== base) begin
         errors++; $display("FAIL flush_cnt got=%0d want=%0d", retire_cnt, base);
      end
`endif
   endtask

   task automatic test_async_reset();
      drive_idle();
      drive_lane(0, 5'd6, 32'h6666_6666, 0, 2'd2, 0, 2'd0);
      drive_lane(1, 5'd8, 32'h8888_8888, 0, 2'd2, 0, 2'd0);
      clock_edge();
      drive_idle();
      #2;
      i_rst_n = 0;
      #1;
      checks++;
      if (o_rd_wen !== '0 || o_rd_idx !== '0 || o_rd_wdata !== '0) begin
         errors++;
         $display("FAIL async_reset wen=%b idx=%h wdata=%h want all zero", o_rd_wen, o_rd_idx, o_rd_wdata);
      end
`ifdef LETC_CORE_STAGE_W_RETIRE_CNT_EN
      checks++;
      if (retire_cnt !== '0) begin
         errors++; $display("FAIL async_reset_cnt got=%0d want=0", retire_cnt);
      end
`endif
      model_reset();
      #1;
      i_rst_n = 1;
      clock_edge();
   endtask

   task automatic test_wrap();
`ifdef LETC_CORE_STAGE_W_RETIRE_CNT_EN
      // Fresh from reset: 16 single-lane retires wrap a 4-bit counter to 0.
      for (int c = 0; c < 16; c++) begin
         drive_idle();
         drive_lane(0, 5'd2, 32'(c), 0, 2'd2, 0, 2'd0);
         clock_edge();
      end
      drive_idle(); #2;
      checks++;
      if (retire_cnt !== 4'd15) begin
         errors++; $display("FAIL wrap_pre got=%0d want=15", retire_cnt);
      end
      clock_edge(); #2;
      checks++;
      if (retire_cnt !== 4'd0) begin
         errors++; $display("FAIL wrap got=%0d want=0", retire_cnt);
      end
`endif
   endtask

   task automatic test_random();
      logic [LANES-1:0] exp_wen;
      int               last[32];
      logic             en;
      for (int it = 0; it < 400; it++) begin
         i_stage_stall = ($urandom_range(0, 3) == 0);
         i_stage_flush = ($urandom_range(0, 9) == 0);
         for (int k = 0; k < LANES; k++) begin
            i_e2_valid[k]        = $urandom_range(0, 3) != 0;
            i_e2_rd_idx[k]       = 5'($urandom_range(0, 3));
            i_e2_rd_wen[k]       = $urandom_range(0, 4) != 0;
            i_e2_wdata[k]        = $urandom;
            i_e2_is_load[k]      = $urandom_range(0, 1);
            i_e2_mem_size[k]     = 2'($urandom_range(0, 3));
            i_e2_mem_unsigned[k] = $urandom_range(0, 1);
            i_e2_byte_off[k]     = 2'($urandom_range(0, 3));
         end
         #2;
         // Youngest enabled lane per rd owns the write.
         for (int r = 0; r < 32; r++) last[r] = -1;
         for (int k = 0; k < LANES; k++) begin
            if (m_valid[k] && m_wen[k] && m_idx[k] != 0 && !i_stage_stall) last[m_idx[k]] = k;
         end
         for (int k = 0; k < LANES; k++) begin
            en = m_valid[k] && m_wen[k] && m_idx[k] != 0 && !i_stage_stall;
            exp_wen[k] = en && (last[m_idx[k]] == k);
         end
         checks++;
         if (o_rd_wen !== exp_wen) begin
            errors++; $display("FAIL rand_wen it=%0d got=%b want=%b", it, o_rd_wen, exp_wen);
         end
         for (int k = 0; k < LANES; k++) begin
            checks++;
            if (o_rd_idx[k] !== m_idx[k] ||
                o_rd_wdata[k] !== (m_load[k] ? ref_fmt(m_data[k], m_size[k], m_uns[k], m_off[k]) : m_data[k])) begin
               errors++;
               $display("FAIL rand_lane it=%0d lane=%0d idx=%0d wdata=%h want idx=%0d wdata=%h", it, k,
                        o_rd_idx[k], o_rd_wdata[k], m_idx[k],
                        m_load[k] ? ref_fmt(m_data[k], m_size[k], m_uns[k], m_off[k]) : m_data[k]);
            end
         end
         checks++;
         if (o_stage_ready !== !i_stage_stall) begin
            errors++; $display("FAIL rand_ready it=%0d got=%b want=%b", it, o_stage_ready, !i_stage_stall);
         end
`ifdef LETC_CORE_STAGE_W_RETIRE_CNT_EN
         checks++;
         if (retire_cnt !== m_cnt) begin
            errors++; $display("FAIL rand_cnt it=%0d got=%0d want=%0d", it, retire_cnt, m_cnt);
         end
`endif
         clock_edge();
      end
      drive_idle();
   endtask

   initial begin
      test_reset();
      test_single_alu();
      test_loads();
      test_conflict();
      test_stall();
      test_flush();
      test_async_reset();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout bench did not complete");
      $fatal(1);
   end

endmodule
